// File: rtl/bakraid_gfx_pkg.sv
// ============================================================================
// Module   : bakraid_gfx_pkg
// Purpose  : Shared types and constants for the Bakraid graphics-ROM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bakraid_gfx_pkg;

   localparam int NREQ     = 4;
   localparam int IDXW     = 2;
   localparam int REQ_OBJ  = 0;
   localparam int REQ_SCR0 = 1;
   localparam int REQ_SCR1 = 2;
   localparam int REQ_SCR2 = 3;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   // Bits needed for a watchdog counter that reaches the given limit.
   function automatic int cnt_width(input int limit);
      return $clog2(limit + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/bakraid_rr_pick.sv
// ============================================================================
// Module   : bakraid_rr_pick
// Purpose  : Combinational cyclic first-one finder: returns the first set
//            request bit at or after the pointer, wrapping around.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bakraid_rr_pick
   import bakraid_gfx_pkg::*;
(
   input  logic [NREQ-1:0] i_req,
   input  logic [IDXW-1:0] i_ptr,
   output logic [IDXW-1:0] o_win,
   output logic            o_vld
);

   logic [IDXW-1:0] w_idx;

   // Scan from farthest to nearest so the nearest hit is the one that sticks.
   always_comb begin
      o_win = i_ptr;
      o_vld = 1'b0;
      w_idx = i_ptr;
      for (int k = NREQ - 1; k >= 0; k--) begin
         w_idx = i_ptr + IDXW'(k);
         if (i_req[w_idx]) begin
            o_win = w_idx;
            o_vld = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/bakraid_gfx_arbiter.sv
// ============================================================================
// Module   : bakraid_gfx_arbiter
// Purpose  : Shares one graphics-ROM read port between the four GP9001 tile
//            fetchers (OBJ, SCR0, SCR1, SCR2) with round-robin arbitration
//            and a per-transaction watchdog.
// Config   : BAKRAID_GFXARB_OBJPRIO_EN - OBJ wins whenever eligible, scroll
//            layers round-robin among themselves.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bakraid_gfx_arbiter
   import bakraid_gfx_pkg::*;
#(
   parameter int AW      = 22,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic [NREQ-1:0]    REQ_CS,
   input  logic [NREQ*AW-1:0] REQ_ADDR,
   output logic [NREQ-1:0]    REQ_OK,
   output logic [NREQ*DW-1:0] REQ_DOUT,
   output logic               ROM_CS,
   output logic [AW-1:0]      ROM_ADDR,
   input  logic               ROM_OK,
   input  logic [DW-1:0]      ROM_DOUT,
   output logic               BUSY,
   output logic               TIMEOUT_ERR
);

   localparam int            CW       = cnt_width(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   state_t          r_state;
   logic [IDXW-1:0] r_ptr;
   logic [IDXW-1:0] r_win;
   logic [CW-1:0]   r_cnt;
   logic            r_rom_cs;
   logic [AW-1:0]   r_rom_addr;
   logic            r_err;

   logic [NREQ-1:0] w_req_ok;
   logic [NREQ-1:0] w_elig;
   logic [NREQ-1:0] w_pick_req;
   logic [IDXW-1:0] w_pick_win;
   logic            w_pick_vld;
   logic [IDXW-1:0] w_win;
   logic            w_vld;
   logic            w_adv;
   logic [AW-1:0]   w_sel_addr;
   logic            w_grant;
   logic            w_done;

   assign w_elig = REQ_CS & ~w_req_ok;

`ifdef BAKRAID_GFXARB_OBJPRIO_EN
   // OBJ bypasses the rotation; the pointer only tracks scroll grants.
   assign w_pick_req = w_elig & ~(NREQ'(1) << REQ_OBJ);
   assign w_win      = w_elig[REQ_OBJ] ? IDXW'(REQ_OBJ) : w_pick_win;
   assign w_vld      = w_elig[REQ_OBJ] | w_pick_vld;
   assign w_adv      = ~w_elig[REQ_OBJ];
`else
   assign w_pick_req = w_elig;
   assign w_win      = w_pick_win;
   assign w_vld      = w_pick_vld;
   assign w_adv      = 1'b1;
`endif

   bakraid_rr_pick u_pick (
      .i_req (w_pick_req),
      .i_ptr (r_ptr),
      .o_win (w_pick_win),
      .o_vld (w_pick_vld)
   );

   assign w_sel_addr = REQ_ADDR[w_win*AW +: AW];
   assign w_grant    = (r_state == ST_IDLE) & w_vld;
   // The first BUSY cycle (count 0) ignores ROM_OK: it may belong to the
   // previous address.
   assign w_done     = (r_state == ST_BUSY) & ROM_OK & (r_cnt != '0);

   // Transaction sequencer: grant, wait for data or watchdog, release.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state    <= ST_IDLE;
         r_ptr      <= '0;
         r_win      <= '0;
         r_cnt      <= '0;
         r_rom_cs   <= 1'b0;
         r_rom_addr <= '0;
         r_err      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_vld) begin
                  r_win      <= w_win;
                  r_rom_addr <= w_sel_addr;
                  r_rom_cs   <= 1'b1;
                  r_cnt      <= '0;
                  r_state    <= ST_BUSY;
                  if (w_adv) begin
                     r_ptr <= w_win + IDXW'(1);
                  end
               end
            end
            ST_BUSY: begin
               if (w_done) begin
                  r_rom_cs <= 1'b0;
                  r_state  <= ST_IDLE;
               end else if (r_cnt == CNT_LAST) begin
                  r_rom_cs <= 1'b0;
                  r_err    <= 1'b1;
                  r_state  <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   generate
      for (genvar i = 0; i < NREQ; i++) begin : g_req
         logic [AW-1:0] r_gaddr;
         logic [DW-1:0] r_dout;
         logic          r_ok;
         logic          w_clr;
         logic          w_set;

         // Dropped CS or a new address invalidates the delivered word.
         assign w_clr = ~REQ_CS[i] | (REQ_ADDR[i*AW +: AW] != r_gaddr);
         assign w_set = w_done & (r_win == IDXW'(i));

         // Per-requester grant address, read data and sticky data-valid.
         always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET) begin
               r_gaddr <= '0;
               r_dout  <= '0;
               r_ok    <= 1'b0;
            end else begin
               if (w_grant && (w_win == IDXW'(i))) begin
                  r_gaddr <= w_sel_addr;
               end
               if (w_set) begin
                  r_dout <= ROM_DOUT;
               end
               r_ok <= ~w_clr & (w_set | r_ok);
            end
         end

         assign w_req_ok[i]            = r_ok;
         assign REQ_DOUT[i*DW +: DW]   = r_dout;
      end
   endgenerate

   assign REQ_OK      = w_req_ok;
   assign ROM_CS      = r_rom_cs;
   assign ROM_ADDR    = r_rom_addr;
   assign BUSY        = (r_state == ST_BUSY);
   assign TIMEOUT_ERR = r_err;

endmodule

`default_nettype wire

// File: tb/tb_bakraid_gfx_arbiter.sv
// ============================================================================
// Module   : tb_bakraid_gfx_arbiter
// Purpose  : Directed self-checking bench for bakraid_gfx_arbiter.
// Config   : BAKRAID_GFXARB_OBJPRIO_EN enables the OBJ-priority scenario.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bakraid_gfx_arbiter;

   logic          CLK = 1'b0;
   logic          RESET = 1'b0;
   logic [3:0]    REQ_CS = '0;
   logic [87:0]   REQ_ADDR = '0;
   logic [3:0]    REQ_OK;
   logic [127:0]  REQ_DOUT;
   logic          ROM_CS;
   logic [21:0]   ROM_ADDR;
   logic          ROM_OK = 1'b0;
   logic [31:0]   ROM_DOUT = '0;
   logic          BUSY;
   logic          TIMEOUT_ERR;

   int total = 0;
   int bad   = 0;

   // ROM responder model state
   logic rom_en  = 1'b0;
   int   rom_lat = 2;
   int   rom_cnt = 0;

   bakraid_gfx_arbiter #(.AW(22), .DW(32), .TIMEOUT(255)) dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .REQ_CS      (REQ_CS),
      .REQ_ADDR    (REQ_ADDR),
      .REQ_OK      (REQ_OK),
      .REQ_DOUT    (REQ_DOUT),
      .ROM_CS      (ROM_CS),
      .ROM_ADDR    (ROM_ADDR),
      .ROM_OK      (ROM_OK),
      .ROM_DOUT    (ROM_DOUT),
      .BUSY        (BUSY),
      .TIMEOUT_ERR (TIMEOUT_ERR)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] romdata(input logic [21:0] a);
      return {10'h2B5, a};
   endfunction

   function automatic logic [31:0] dout_of(input int i);
      return REQ_DOUT[i*32 +: 32];
   endfunction

   task automatic set_addr(input int i, input logic [21:0] a);
      REQ_ADDR[i*22 +: 22] = a;
   endtask

   // One clock: step past the edge, then let the ROM model react.
   task automatic tick;
      @(posedge CLK);
      #1;
      if (rom_en) begin
         if (ROM_CS) begin
            rom_cnt++;
            if (rom_cnt >= rom_lat) begin
               ROM_OK   = 1'b1;
               ROM_DOUT = romdata(ROM_ADDR);
            end else begin
               ROM_OK = 1'b0;
            end
         end else begin
            rom_cnt = 0;
            ROM_OK  = 1'b0;
         end
      end
   endtask

   task automatic do_reset;
      RESET    = 1'b0;
      REQ_CS   = '0;
      REQ_ADDR = '0;
      ROM_OK   = 1'b0;
      ROM_DOUT = '0;
      rom_en   = 1'b0;
      rom_cnt  = 0;
      tick;
      tick;
      RESET = 1'b1;
   endtask

   task automatic wait_ok(input int i, output logic seen);
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         tick;
         seen = REQ_OK[i];
      end
   endtask

   task automatic test_reset;
      do_reset;
      total++; if (REQ_OK !== 4'b0) begin bad++; $display("FAIL rst_req_ok: got %b want 0000", REQ_OK); end
      total++; if (REQ_DOUT !== 128'b0) begin bad++; $display("FAIL rst_req_dout: got %h want 0", REQ_DOUT); end
      total++; if (ROM_CS !== 1'b0) begin bad++; $display("FAIL rst_rom_cs: got %b want 0", ROM_CS); end
      total++; if (ROM_ADDR !== 22'h0) begin bad++; $display("FAIL rst_rom_addr: got %h want 0", ROM_ADDR); end
      total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", BUSY); end
      total++; if (TIMEOUT_ERR !== 1'b0) begin bad++; $display("FAIL rst_terr: got %b want 0", TIMEOUT_ERR); end
   endtask

   task automatic test_single_fetch;
      do_reset;
      set_addr(1, 22'h12345);
      REQ_CS = 4'b0010;
      tick;   // cycle 1
      total++; if (ROM_CS !== 1'b1) begin bad++; $display("FAIL single_cs: got %b want 1", ROM_CS); end
      total++; if (ROM_ADDR !== 22'h12345) begin bad++; $display("FAIL single_addr: got %h want 12345", ROM_ADDR); end
      total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", BUSY); end
      tick;   // cycle 2
      tick;   // cycle 3
      total++; if (REQ_OK !== 4'b0000 || ROM_CS !== 1'b1) begin bad++; $display("FAIL single_wait: got ok=%b cs=%b want ok=0000 cs=1", REQ_OK, ROM_CS); end
      tick;   // cycle 4
      ROM_OK   = 1'b1;
      ROM_DOUT = 32'hDEADBEEF;
      tick;   // cycle 5
      ROM_OK = 1'b0;
      total++; if (REQ_OK !== 4'b0010) begin bad++; $display("FAIL single_ok: got %b want 0010", REQ_OK); end
      total++; if (dout_of(1) !== 32'hDEADBEEF) begin bad++; $display("FAIL single_dout: got %h want deadbeef", dout_of(1)); end
      total++; if (ROM_CS !== 1'b0) begin bad++; $display("FAIL single_cs_drop: got %b want 0", ROM_CS); end
      tick;
      tick;
      total++; if (REQ_OK !== 4'b0010 || ROM_CS !== 1'b0) begin bad++; $display("FAIL single_hold: got ok=%b cs=%b want ok=0010 cs=0", REQ_OK, ROM_CS); end
      REQ_CS = 4'b0000;
      tick;
      total++; if (REQ_OK !== 4'b0000) begin bad++; $display("FAIL single_clear: got %b want 0000", REQ_OK); end
      total++; if (dout_of(1) !== 32'hDEADBEEF) begin bad++; $display("FAIL single_dout_hold: got %h want deadbeef", dout_of(1)); end
   endtask

   task automatic test_round_robin;
      int   ngrant;
      int   cyc;
      int   last_rise;
      logic prev_cs;
      logic round2;
      logic seen;
      do_reset;
      rom_en  = 1'b1;
      rom_lat = 2;
      for (int i = 0; i < 4; i++) set_addr(i, 22'h1000 + 22'(i * 16));
      REQ_CS    = 4'hF;
      ngrant    = 0;
      cyc       = 0;
      last_rise = 0;
      prev_cs   = 1'b0;
      round2    = 1'b0;
      while (ngrant < 8 && cyc < 100) begin
         tick;
         cyc++;
         if (ROM_CS && !prev_cs) begin
            total++; if (int'(ROM_ADDR[5:4]) != (ngrant % 4)) begin bad++; $display("FAIL rr_order: grant %0d got idx %0d want %0d", ngrant, ROM_ADDR[5:4], ngrant % 4); end
            if ((ngrant % 4) != 0) begin
               total++; if (cyc - last_rise != 3) begin bad++; $display("FAIL rr_spacing: grant %0d got %0d cycles want 3", ngrant, cyc - last_rise); end
            end
            last_rise = cyc;
            ngrant++;
         end
         prev_cs = ROM_CS;
         if (!round2 && ngrant == 4 && REQ_OK == 4'hF) begin
            for (int i = 0; i < 4; i++) begin
               total++; if (dout_of(i) !== romdata(22'h1000 + 22'(i * 16))) begin bad++; $display("FAIL rr_dout1: req %0d got %h want %h", i, dout_of(i), romdata(22'h1000 + 22'(i * 16))); end
            end
            for (int i = 0; i < 4; i++) set_addr(i, 22'h2000 + 22'(i * 16));
            round2 = 1'b1;
         end
      end
      total++; if (ngrant != 8) begin bad++; $display("FAIL rr_count: got %0d grants want 8", ngrant); end
      wait_ok(3, seen);
      total++; if (REQ_OK !== 4'hF) begin bad++; $display("FAIL rr_ok2: got %b want 1111", REQ_OK); end
      for (int i = 0; i < 4; i++) begin
         total++; if (dout_of(i) !== romdata(22'h2000 + 22'(i * 16))) begin bad++; $display("FAIL rr_dout2: req %0d got %h want %h", i, dout_of(i), romdata(22'h2000 + 22'(i * 16))); end
      end
   endtask

   task automatic test_addr_change;
      logic seen;
      do_reset;
      rom_en  = 1'b1;
      rom_lat = 2;
      set_addr(2, 22'h100);
      REQ_CS = 4'b0100;
      wait_ok(2, seen);
      total++; if (!seen || dout_of(2) !== romdata(22'h100)) begin bad++; $display("FAIL addr_first: got ok=%b dout=%h want ok=1 dout=%h", seen, dout_of(2), romdata(22'h100)); end
      set_addr(2, 22'h140);
      tick;
      total++; if (REQ_OK[2] !== 1'b0) begin bad++; $display("FAIL addr_ok_drop: got %b want 0", REQ_OK[2]); end
      tick;
      total++; if (ROM_CS !== 1'b1 || ROM_ADDR !== 22'h140) begin bad++; $display("FAIL addr_refetch: got cs=%b addr=%h want cs=1 addr=140", ROM_CS, ROM_ADDR); end
      wait_ok(2, seen);
      total++; if (!seen || dout_of(2) !== romdata(22'h140)) begin bad++; $display("FAIL addr_second: got ok=%b dout=%h want ok=1 dout=%h", seen, dout_of(2), romdata(22'h140)); end
   endtask

   task automatic test_stale_ok;
      do_reset;
      ROM_OK   = 1'b1;
      ROM_DOUT = 32'hCAFEF00D;
      set_addr(0, 22'h55);
      REQ_CS = 4'b0001;
      tick;   // cycle 1: first BUSY cycle
      total++; if (ROM_CS !== 1'b1 || ROM_ADDR !== 22'h55) begin bad++; $display("FAIL stale_grant: got cs=%b addr=%h want cs=1 addr=55", ROM_CS, ROM_ADDR); end
      tick;   // cycle 2: stale OK must not have completed it
      total++; if (REQ_OK !== 4'b0000 || ROM_CS !== 1'b1) begin bad++; $display("FAIL stale_ignored: got ok=%b cs=%b want ok=0000 cs=1", REQ_OK, ROM_CS); end
      tick;   // cycle 3
      total++; if (REQ_OK !== 4'b0001 || ROM_CS !== 1'b0) begin bad++; $display("FAIL stale_done: got ok=%b cs=%b want ok=0001 cs=0", REQ_OK, ROM_CS); end
      total++; if (dout_of(0) !== 32'hCAFEF00D) begin bad++; $display("FAIL stale_dout: got %h want cafef00d", dout_of(0)); end
      ROM_OK = 1'b0;
      REQ_CS = 4'b0000;
      tick;
   endtask

   task automatic test_watchdog;
      int hi;
      do_reset;
      set_addr(3, 22'h3AA);
      REQ_CS = 4'b1000;
      hi = 0;
      tick;
      for (int k = 0; k < 400 && ROM_CS; k++) begin
         hi++;
         tick;
      end
      total++; if (hi != 255) begin bad++; $display("FAIL wd_cycles: got %0d busy cycles want 255", hi); end
      total++; if (TIMEOUT_ERR !== 1'b1) begin bad++; $display("FAIL wd_err: got %b want 1", TIMEOUT_ERR); end
      total++; if (REQ_OK !== 4'b0000 || BUSY !== 1'b0) begin bad++; $display("FAIL wd_abort: got ok=%b busy=%b want ok=0000 busy=0", REQ_OK, BUSY); end
      tick;
      total++; if (ROM_CS !== 1'b1 || ROM_ADDR !== 22'h3AA) begin bad++; $display("FAIL wd_regrant: got cs=%b addr=%h want cs=1 addr=3aa", ROM_CS, ROM_ADDR); end
      total++; if (TIMEOUT_ERR !== 1'b1) begin bad++; $display("FAIL wd_sticky: got %b want 1", TIMEOUT_ERR); end
   endtask

   // Continues from the watchdog re-grant: still BUSY with TIMEOUT_ERR set.
   task automatic test_reset_mid_busy;
      ROM_OK   = 1'b1;
      ROM_DOUT = 32'h11112222;
      #3;
      RESET = 1'b0;
      #1;
      total++; if (ROM_CS !== 1'b0 || BUSY !== 1'b0) begin bad++; $display("FAIL arst_cs: got cs=%b busy=%b want 0 0", ROM_CS, BUSY); end
      total++; if (TIMEOUT_ERR !== 1'b0) begin bad++; $display("FAIL arst_terr: got %b want 0", TIMEOUT_ERR); end
      total++; if (ROM_ADDR !== 22'h0 || REQ_OK !== 4'b0) begin bad++; $display("FAIL arst_addr: got addr=%h ok=%b want 0 0000", ROM_ADDR, REQ_OK); end
      REQ_CS = 4'b0000;
      tick;
      tick;
      RESET = 1'b1;
      tick;
      tick;
      tick;
      total++; if (REQ_OK !== 4'b0 || REQ_DOUT !== 128'b0 || BUSY !== 1'b0) begin bad++; $display("FAIL arst_release: got ok=%b dout=%h busy=%b want 0", REQ_OK, REQ_DOUT, BUSY); end
      ROM_OK = 1'b0;
   endtask

`ifdef BAKRAID_GFXARB_OBJPRIO_EN
   task automatic test_objprio;
      int          grants;
      int          scr;
      logic        prev_cs;
      logic [21:0] obj_a;
      do_reset;
      rom_en  = 1'b1;
      rom_lat = 2;
      obj_a   = 22'h400;
      set_addr(0, obj_a);
      set_addr(2, 22'h800);
      REQ_CS  = 4'b0101;
      grants  = 0;
      scr     = 0;
      prev_cs = 1'b0;
      for (int k = 0; k < 60; k++) begin
         tick;
         if (ROM_CS && !prev_cs) begin
            grants++;
            if (ROM_ADDR[11]) scr++;
         end
         prev_cs = ROM_CS;
         if (ROM_OK) begin
            obj_a = obj_a + 22'h1;
            set_addr(0, obj_a);
         end
      end
      total++; if (grants < 10) begin bad++; $display("FAIL prio_grants: got %0d want >=10", grants); end
      total++; if (scr != 0) begin bad++; $display("FAIL prio_scr: got %0d scroll grants want 0", scr); end
   endtask
`endif

   initial begin
      test_reset;
      test_single_fetch;
      test_round_robin;
      test_addr_change;
      test_stale_ok;
      test_watchdog;
      test_reset_mid_busy;
`ifdef BAKRAID_GFXARB_OBJPRIO_EN
      test_objprio;
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
